// File: rtl/oversampled_tx.sv
// rtl/oversampled_tx.sv - byte FIFO + UART-style framer emitting 4x-replicated line bits, 2 per clock
// Optional TX_PARITY_EN: 12-bit frame {1,1,even parity,d,0} over 6 words instead of 10 bits over 5.
module oversampled_tx #(
  parameter int FIFO_DEPTH   = 4,
  parameter int TRAIN_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          train_req,
  output logic [7:0]                    tx_word,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef TX_PARITY_EN
  localparam int FRAME_BITS = 12;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int NWORDS = FRAME_BITS / 2;
  localparam int TCW    = $clog2(TRAIN_CYCLES + 1);
  localparam logic [TCW-1:0] TRAIN_END = TCW'(TRAIN_CYCLES);

  typedef enum logic [1:0] {TRAIN, IDLE, FRAME} state_t;

  state_t                  state, state_nxt;
  logic [7:0]              mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr, rd_ptr;
  logic                    full, empty, push, load;
  logic [7:0]              head;
  logic [FRAME_BITS-1:0]   frame_new, shift, shift_nxt;
  logic [2:0]              word_cnt, word_cnt_nxt;
  logic [TCW-1:0]          train_cnt, train_cnt_nxt;
  logic                    train_pend, train_pend_nxt;
  logic [7:0]              tx_word_nxt;
  logic                    frame_done;

  function automatic logic [7:0] enc(input logic [1:0] b);
    return {{4{b[1]}}, {4{b[0]}}};
  endfunction

  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign empty      = (fifo_level == '0);
  assign s_ready    = (state != TRAIN) && !full;
  assign push       = s_valid && s_ready;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign busy       = (state != IDLE);
  assign frame_done = (word_cnt == 3'(NWORDS));

`ifdef TX_PARITY_EN
  assign frame_new = {2'b11, ^head, head, 1'b0};
`else
  assign frame_new = {1'b1, head, 1'b0};
`endif

  // A pending or fresh train request always wins over loading the next byte.
  assign load = !empty && !train_req &&
                ((state == IDLE) || ((state == FRAME) && frame_done && !train_pend));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= TRAIN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TRAIN: if (!train_req && train_cnt == TRAIN_END) state_nxt = IDLE;
      IDLE:  if (train_req) state_nxt = TRAIN;
             else if (!empty) state_nxt = FRAME;
      FRAME: if (frame_done) begin
               if (train_req || train_pend) state_nxt = TRAIN;
               else if (empty)              state_nxt = IDLE;
             end
      default: state_nxt = TRAIN;
    endcase
  end

  always_comb begin
    tx_word_nxt    = 8'hFF;
    shift_nxt      = shift;
    word_cnt_nxt   = word_cnt;
    train_cnt_nxt  = train_cnt;
    train_pend_nxt = train_pend;
    case (state)
      TRAIN: begin
        train_pend_nxt = 1'b0;
        if (train_req) begin
          train_cnt_nxt = '0;
          tx_word_nxt   = 8'h0F;
        end else if (train_cnt != TRAIN_END) begin
          train_cnt_nxt = train_cnt + 1'b1;
          tx_word_nxt   = 8'h0F;
        end
      end
      IDLE: if (train_req) train_cnt_nxt = '0;
      FRAME: begin
        if (!frame_done) begin
          tx_word_nxt  = enc(shift[1:0]);
          shift_nxt    = shift >> 2;
          word_cnt_nxt = word_cnt + 3'd1;
          if (train_req) train_pend_nxt = 1'b1;
        end else if (train_req || train_pend) begin
          train_cnt_nxt  = '0;
          train_pend_nxt = 1'b0;
        end
      end
      default: ;
    endcase
    // The first word of a frame leaves on the same edge that pops the byte.
    if (load) begin
      tx_word_nxt  = enc(frame_new[1:0]);
      shift_nxt    = frame_new >> 2;
      word_cnt_nxt = 3'd1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      tx_word    <= 8'hFF;
      shift      <= '0;
      word_cnt   <= '0;
      train_cnt  <= '0;
      train_pend <= 1'b0;
    end else begin
      tx_word    <= tx_word_nxt;
      shift      <= shift_nxt;
      word_cnt   <= word_cnt_nxt;
      train_cnt  <= train_cnt_nxt;
      train_pend <= train_pend_nxt;
    end
  end

endmodule

// File: tb/tb_oversampled_tx.sv
// tb/tb_oversampled_tx.sv - scoreboard bench: line decoder monitor against a queue of accepted bytes
module tb_oversampled_tx;
`ifdef TX_PARITY_EN
  localparam int NW = 6;
`else
  localparam int NW = 5;
`endif

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       train_req = 1'b0;
  logic       s_ready;
  logic [7:0] tx_word;
  logic       busy;
  logic [2:0] fifo_level;

  int total = 0, bad = 0;
  int accepted = 0, started = 0;
  int run = 0, max_run = 0;
  logic [7:0] exp_q[$];

  oversampled_tx #(.FIFO_DEPTH(4), .TRAIN_CYCLES(64)) dut (
    .clk(clk), .areset(areset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .train_req(train_req), .tx_word(tx_word), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Line bits of a frame, LSB first, then paired two per word with 4x replication.
  function automatic logic [7:0] model_word(input logic [7:0] d, input int idx);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef TX_PARITY_EN
    bits.push_back(^d);
    bits.push_back(1'b1);
    bits.push_back(1'b1);
`else
    bits.push_back(1'b1);
`endif
    return {{4{bits[2*idx+1]}}, {4{bits[2*idx]}}};
  endfunction

  logic [7:0] cap [NW];
  logic       mb  [2*NW];
  logic [7:0] dd;
  int         widx = 0;
  bit         in_frame = 0;

  always @(negedge clk) begin
    if (areset) begin
      in_frame = 0; widx = 0; started = 0; run = 0;
    end else begin
      if (!in_frame && tx_word[3:0] == 4'h0) begin
        in_frame = 1; widx = 0; started++;
      end
      if (in_frame) begin
        cap[widx] = tx_word;
        widx++;
        run++;
        if (run > max_run) max_run = run;
        chk("busy_in_frame", int'(busy), 1);
        if (widx == NW) begin
          in_frame = 0;
          for (int w = 0; w < NW; w++) begin
            chk("word_shape", int'((cap[w][3:0] == 4'h0 || cap[w][3:0] == 4'hF) &&
                                   (cap[w][7:4] == 4'h0 || cap[w][7:4] == 4'hF)), 1);
            mb[2*w]   = cap[w][0];
            mb[2*w+1] = cap[w][4];
          end
          for (int i = 0; i < 8; i++) dd[i] = mb[i+1];
`ifdef TX_PARITY_EN
          chk("parity_bit", int'(mb[9]), int'(^dd));
          chk("stop_bits", int'(mb[10] & mb[11]), 1);
`else
          chk("stop_bit", int'(mb[9]), 1);
`endif
          if (exp_q.size() == 0) chk("unexpected_frame", int'(dd), -1);
          else                   chk("frame_data", int'(dd), int'(exp_q.pop_front()));
        end
      end else begin
        run = 0;
      end
      chk("fifo_level", int'(fifo_level), accepted - started);
    end
  end

  task automatic push_byte(input logic [7:0] d);
    int w = 0;
    s_data = d;
    s_valid = 1'b1;
    while (!s_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) begin
      chk("push_ready_timeout", int'(s_ready), 1);
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
      accepted++;
      exp_q.push_back(d);
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  task automatic wait_train(input string name, input int lvl);
    int w = 0, n = 0;
    while (tx_word != 8'h0F && w < 200) begin
      @(negedge clk);
      w++;
    end
    while (tx_word == 8'h0F && n < 300) begin
      if (n == 32) begin
        chk({name, "_ready_low"}, int'(s_ready), 0);
        chk({name, "_level"}, int'(fifo_level), lvl);
      end
      @(negedge clk);
      n++;
    end
    chk({name, "_len"}, n, 64);
    chk({name, "_idle_word"}, int'(tx_word), 8'hFF);
    chk({name, "_ready_up"}, int'(s_ready), 1);
    chk({name, "_busy_low"}, int'(busy), 0);
  endtask

  task automatic single_frame(input logic [7:0] d);
    push_byte(d);
    chk("latency_pre", int'(tx_word), 8'hFF);
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      chk("single_word", int'(tx_word), int'(model_word(d, i)));
      chk("single_busy", int'(busy), 1);
    end
    @(negedge clk);
    chk("single_after", int'(tx_word), 8'hFF);
    chk("single_busy_end", int'(busy), 0);
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || busy) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx_word", int'(tx_word), 8'hFF);
    chk("rst_busy", int'(busy), 1);
    chk("rst_ready", int'(s_ready), 0);
    chk("rst_level", int'(fifo_level), 0);
    #1 areset = 1'b0;
    wait_train("train_init", 0);

    single_frame(8'hA5);

    for (int i = 0; i < 5; i++) push_byte(8'($urandom));
    chk("burst_ready_full", int'(s_ready), 0);
    chk("burst_level_full", int'(fifo_level), 4);
    drain();
    chk("burst_gapfree", max_run, 5 * NW);

    push_byte(8'($urandom));
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    @(negedge clk);
    train_req = 1'b1;
    @(negedge clk);
    train_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("train_gap_word", int'(tx_word), 8'hFF);
    chk("train_gap_busy", int'(busy), 1);
    chk("train_gap_level", int'(fifo_level), 2);
    wait_train("train_req", 2);
    drain();

    push_byte(8'($urandom));
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    @(negedge clk);
    #1 areset = 1'b1;
    exp_q.delete();
    accepted = 0;
    #1;
    chk("abort_tx_word", int'(tx_word), 8'hFF);
    chk("abort_level", int'(fifo_level), 0);
    chk("abort_busy", int'(busy), 1);
    chk("abort_ready", int'(s_ready), 0);
    repeat (2) @(negedge clk);
    #1 areset = 1'b0;
    wait_train("train_rst", 0);

    single_frame(8'h07);

    for (int k = 0; k < 24; k++) begin
      int gap;
      gap = $urandom_range(0, 6);
      repeat (gap) begin
        train_req = ($urandom_range(0, 29) == 0);
        @(negedge clk);
        train_req = 1'b0;
      end
      push_byte(8'($urandom));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
